pcie_dplbuf_arb: RTL and testbench



---
 rtl/pcie_dplbuf_arb_pkg.sv | 25 ++
 rtl/pcie_dplbuf_arb_rr_arb_pick.sv | 33 +++
 rtl/pcie_dplbuf_arb.sv | 184 ++++++++++++++++++
 tb/tb_pcie_dplbuf_arb.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pcie_dplbuf_arb_pkg.sv
// Shared types and constants for the DPL buffer write-port arbiter.
package pcie_dplbuf_arb_pkg;

  typedef enum logic [1:0] {
    IDLE_ST = 2'd0,
    GNT_ST  = 2'd1,
    WAIT_ST = 2'd2,
    XFER_ST = 2'd3
  } dplbuf_arb_st_e;

  localparam int unsigned DPLBUF_BEATS_PER_BLK = 128;
  localparam int unsigned DPLBUF_ARB_ERR_W     = 3;
  localparam int unsigned DPLBUF_DATA_W        = 256;

  // Bit positions inside the sticky error vector.
  localparam int unsigned ERR_MULTI   = 0;
  localparam int unsigned ERR_FOREIGN = 1;
  localparam int unsigned ERR_TIMEOUT = 2;

  // True when more than one bit of v is set.
  function automatic logic multi_hot(input logic [15:0] v);
    return (v & (v - 16'd1)) != 16'd0;
  endfunction

endpackage

// File: rtl/pcie_dplbuf_arb_rr_arb_pick.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module pcie_dplbuf_arb_rr_arb_pick
  import pcie_dplbuf_arb_pkg::*;
#(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = 2
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic              valid_o,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o
);

  int unsigned pos;

  // Walk the requesters starting at ptr and keep the first hit.
  always_comb begin
    valid_o = 1'b0;
    gnt_o   = '0;
    idx_o   = '0;
    pos     = 0;
    for (int unsigned off = 0; off < NumReq; off++) begin
      pos = (32'(ptr_i) + off) % NumReq;
      if (!valid_o && req_i[pos[IdxW-1:0]]) begin
        valid_o                = 1'b1;
        gnt_o[pos[IdxW-1:0]]   = 1'b1;
        idx_o                  = pos[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/pcie_dplbuf_arb.sv
// Round-robin owner of the DPL buffer DMA-write port, one 4KB block per grant.
// Also OR-merges the requester data buses and keeps sticky protocol errors.
module pcie_dplbuf_arb
  import pcie_dplbuf_arb_pkg::*;
#(
  parameter int unsigned pNUM_REQ = 4,
  parameter int unsigned pBEATS   = DPLBUF_BEATS_PER_BLK,
  parameter int unsigned pTIMEOUT = 64
) (
  input  logic                         iCLK,
  input  logic                         iRST_N,
  input  logic [pNUM_REQ-1:0]          iREQ,
  output logic [pNUM_REQ-1:0]          oGNT,
  input  logic [pNUM_REQ*256-1:0]      iDATA,
  input  logic [pNUM_REQ-1:0]          iDATA_V,
  output logic                         oANY_DATA_V,
  input  logic                         iBUF_SPACE_OK,
  output logic [255:0]                 oDATA,
  output logic                         oDATA_V,
  output logic [3:0]                   oOWNER,
  output logic                         oBUSY,
  output logic [31:0]                  oBLK_CNT,
  input  logic                         iERR_CLR,
  output logic [DPLBUF_ARB_ERR_W-1:0]  oERR
);

  localparam int unsigned IdxW  = (pNUM_REQ > 1) ? $clog2(pNUM_REQ) : 1;
  localparam int unsigned WaitW = (pTIMEOUT > 1) ? $clog2(pTIMEOUT) : 1;
  localparam logic [pNUM_REQ-1:0] ReqOne = pNUM_REQ'(1);

  dplbuf_arb_st_e                  state_q, state_d;
  logic [IdxW-1:0]                 owner_q, owner_d;
  logic [pNUM_REQ-1:0]             owner_oh_q, owner_oh_d;
  logic [IdxW-1:0]                 ptr_q, ptr_d;
  logic [WaitW-1:0]                wait_cnt_q, wait_cnt_d;
  logic [7:0]                      beat_cnt_q, beat_cnt_d;
  logic [31:0]                     blk_cnt_q, blk_cnt_d;
  logic [DPLBUF_ARB_ERR_W-1:0]     err_q, err_d;
  logic [255:0]                    data_q, data_or;
  logic                            data_v_q;

  logic                            pick_valid;
  logic [pNUM_REQ-1:0]             pick_gnt;
  logic [IdxW-1:0]                 pick_idx;

  logic                            any_v;
  logic                            owner_beat;
  logic                            foreign_set;
  logic                            timeout_set;

  pcie_dplbuf_arb_rr_arb_pick #(
    .NumReq (pNUM_REQ),
    .IdxW   (IdxW)
  ) u_pick (
    .req_i   (iREQ),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx)
  );

  assign any_v       = |iDATA_V;
  assign oANY_DATA_V = any_v;
  assign owner_beat  = |(iDATA_V & owner_oh_q);

  // Beats outside a granted window, or from anyone but the owner, are foreign.
  assign foreign_set = (state_q == IDLE_ST || state_q == GNT_ST) ? any_v
                                                                 : |(iDATA_V & ~owner_oh_q);

  // Requesters zero their bus when idle, so a plain OR is the merge.
  always_comb begin
    data_or = '0;
    for (int unsigned i = 0; i < pNUM_REQ; i++) begin
      data_or = data_or | iDATA[256*i +: 256];
    end
  end

  // Block-ownership FSM with grant pulse, first-beat timeout and beat counting.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    owner_oh_d  = owner_oh_q;
    ptr_d       = ptr_q;
    wait_cnt_d  = wait_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    blk_cnt_d   = blk_cnt_q;
    timeout_set = 1'b0;

    unique case (state_q)
      IDLE_ST: begin
        // Any in-flight beat blocks a new grant so blocks never overlap on the bus.
        if (pick_valid && iBUF_SPACE_OK && !any_v) begin
          owner_d    = pick_idx;
          owner_oh_d = pick_gnt;
          ptr_d      = (pick_idx == IdxW'(pNUM_REQ - 1)) ? '0 : pick_idx + IdxW'(1);
          state_d    = GNT_ST;
        end
      end
      GNT_ST: begin
        wait_cnt_d = '0;
        beat_cnt_d = '0;
        state_d    = WAIT_ST;
      end
      WAIT_ST: begin
        if (owner_beat) begin
          if (pBEATS == 1) begin
            blk_cnt_d = blk_cnt_q + 32'd1;
            state_d   = IDLE_ST;
          end else begin
            beat_cnt_d = 8'd1;
            state_d    = XFER_ST;
          end
        end else if (wait_cnt_q == WaitW'(pTIMEOUT - 1)) begin
          timeout_set = 1'b1;
          state_d     = IDLE_ST;
        end else begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end
      XFER_ST: begin
        if (owner_beat) begin
          if (beat_cnt_q == 8'(pBEATS - 1)) begin
            blk_cnt_d = blk_cnt_q + 32'd1;
            state_d   = IDLE_ST;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE_ST;
    endcase
  end

  // Sticky errors: clear first so a coincident set condition survives.
  always_comb begin
    err_d              = iERR_CLR ? '0 : err_q;
    err_d[ERR_MULTI]   = err_d[ERR_MULTI] | multi_hot(16'(iDATA_V));
    err_d[ERR_FOREIGN] = err_d[ERR_FOREIGN] | foreign_set;
    err_d[ERR_TIMEOUT] = err_d[ERR_TIMEOUT] | timeout_set;
  end

  // Control and status state.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= IDLE_ST;
      owner_q    <= '0;
      owner_oh_q <= ReqOne;
      ptr_q      <= '0;
      wait_cnt_q <= '0;
      beat_cnt_q <= '0;
      blk_cnt_q  <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      owner_oh_q <= owner_oh_d;
      ptr_q      <= ptr_d;
      wait_cnt_q <= wait_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      blk_cnt_q  <= blk_cnt_d;
      err_q      <= err_d;
    end
  end

  // Merged datapath register, independent of the FSM.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      data_q   <= '0;
      data_v_q <= 1'b0;
    end else begin
      data_q   <= data_or;
      data_v_q <= any_v;
    end
  end

  assign oGNT     = (state_q == GNT_ST) ? owner_oh_q : '0;
  assign oDATA    = data_q;
  assign oDATA_V  = data_v_q;
  assign oOWNER   = 4'(owner_q);
  assign oBUSY    = (state_q != IDLE_ST);
  assign oBLK_CNT = blk_cnt_q;
  assign oERR     = err_q;

endmodule

// File: tb/tb_pcie_dplbuf_arb.sv
// Randomized bench for pcie_dplbuf_arb against a transaction-level reference model.
module tb_pcie_dplbuf_arb;

  localparam int N     = 4;
  localparam int BEATS = 128;
  localparam int TMO   = 64;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [N-1:0]       req = '0;
  logic [N-1:0]       gnt;
  logic [N*256-1:0]   data = '0;
  logic [N-1:0]       dv = '0;
  logic               any_v;
  logic               space = 1'b0;
  logic [255:0]       odata;
  logic               odata_v;
  logic [3:0]         owner;
  logic               busy;
  logic [31:0]        blk_cnt;
  logic               clr = 1'b0;
  logic [2:0]         err;

  always #5 clk = ~clk;

  pcie_dplbuf_arb #(
    .pNUM_REQ (N),
    .pBEATS   (BEATS),
    .pTIMEOUT (TMO)
  ) dut (
    .iCLK          (clk),
    .iRST_N        (rst_n),
    .iREQ          (req),
    .oGNT          (gnt),
    .iDATA         (data),
    .iDATA_V       (dv),
    .oANY_DATA_V   (any_v),
    .iBUF_SPACE_OK (space),
    .oDATA         (odata),
    .oDATA_V       (odata_v),
    .oOWNER        (owner),
    .oBUSY         (busy),
    .oBLK_CNT      (blk_cnt),
    .iERR_CLR      (clr),
    .oERR          (err)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference model: a block is "open" from its grant cycle until the last beat
  // or the timeout; since counts cycles after the grant cycle.
  bit           m_open;
  int           m_owner, m_since, m_beats, m_ptr;
  logic [31:0]  m_blk;
  logic [2:0]   m_err;
  logic [255:0] m_data;
  bit           m_dv;
  int           lat_cur;
  int           grants, timeouts, blocks;
  logic [N-1:0] req_mask;

  task automatic model_reset();
    m_open = 0; m_owner = 0; m_since = 0; m_beats = 0; m_ptr = 0;
    m_blk = '0; m_err = '0; m_data = '0; m_dv = 0;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int w = 0; w < 8; w++) r[32*w +: 32] = $urandom;
    return r;
  endfunction

  task automatic check_outputs();
    logic [N-1:0] exp_gnt;
    exp_gnt = '0;
    if (m_open && m_since == 0) exp_gnt[m_owner] = 1'b1;
    chk("gnt", 256'(gnt), 256'(exp_gnt));
    chk("data", odata, m_data);
    chk("data_v", 256'(odata_v), 256'(m_dv));
    chk("owner", 256'(owner), 256'(m_owner));
    chk("busy", 256'(busy), 256'(m_open));
    chk("blk_cnt", 256'(blk_cnt), 256'(m_blk));
    chk("err", 256'(err), 256'(m_err));
  endtask

  task automatic model_step();
    int  nv;
    bit  multi, foreign, tmo;
    nv = 0; foreign = 0; tmo = 0;
    for (int i = 0; i < N; i++) begin
      if (dv[i]) begin
        nv++;
        if (!m_open || m_since == 0 || i != m_owner) foreign = 1;
      end
    end
    multi = (nv > 1);
    if (!m_open) begin
      if (req != 0 && space && nv == 0) begin
        for (int k = 0; k < N; k++) begin
          if (!m_open && req[(m_ptr + k) % N]) begin
            m_open  = 1;
            m_owner = (m_ptr + k) % N;
          end
        end
        m_ptr   = (m_owner + 1) % N;
        m_since = 0;
        m_beats = 0;
        grants++;
        lat_cur = ($urandom % 10 == 0) ? 1000 : int'($urandom % 12);
      end
    end else if (m_since == 0) begin
      m_since = 1;
    end else begin
      if (dv[m_owner]) begin
        m_beats++;
        if (m_beats == BEATS) begin
          m_open = 0;
          m_blk  = m_blk + 1;
          blocks++;
        end
      end else if (m_beats == 0 && m_since == TMO) begin
        tmo    = 1;
        m_open = 0;
        timeouts++;
      end
      m_since++;
    end
    if (clr) m_err = '0;
    m_err = m_err | {tmo, foreign, multi};
    m_data = '0;
    for (int i = 0; i < N; i++) m_data = m_data | data[256*i +: 256];
    m_dv = (nv != 0);
  endtask

  // One clock: check registered outputs, drive new inputs, advance the model.
  task automatic cycle_step();
    @(negedge clk);
    check_outputs();
    for (int i = 0; i < N; i++) if ($urandom % 16 == 0) req[i] = ~req[i];
    req   = req & req_mask;
    space = ($urandom % 8) != 0;
    clr   = ($urandom % 32) == 0;
    dv    = '0;
    if (m_open && m_since >= 1 && m_since > lat_cur && ($urandom % 5) != 0) dv[m_owner] = 1'b1;
    if ($urandom % 50 == 0) dv[$urandom % N] = 1'b1;
    data = '0;
    for (int i = 0; i < N; i++) if (dv[i]) data[256*i +: 256] = rand256();
    #1;
    chk("any_v", 256'(any_v), 256'(|dv));
    model_step();
  endtask

  initial begin
    int budget;
    grants = 0; timeouts = 0; blocks = 0; lat_cur = 0;
    req_mask = '1;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int c = 0; c < 9000; c++) cycle_step();

    // Drive into the middle of a block, then reset asynchronously.
    budget = 0;
    while (!(m_open && m_beats >= 60) && budget < 4000) begin
      cycle_step();
      budget++;
    end
    chk("reach_mid_block", 256'(m_open && m_beats >= 60), 256'(1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_data_v", 256'(odata_v), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_blk_cnt", 256'(blk_cnt), 256'(0));
    chk("rst_gnt", 256'(gnt), 256'(0));
    chk("rst_err", 256'(err), 256'(0));
    model_reset();
    req = '0; dv = '0; data = '0; clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_mask = 4'b0001;
    req = 4'b0001;
    for (int c = 0; c < 400; c++) cycle_step();
    chk("post_rst_owner0", 256'(m_blk != 0 || grants != 0), 256'(1));
    req_mask = '1;
    for (int c = 0; c < 1500; c++) cycle_step();

    $display("grants %0d, blocks %0d, timeouts %0d", grants, blocks, timeouts);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
